// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// MIPS-subset instruction decode stage with a single-entry registered output
// and a valid/ready handshake on both sides.
//
// Build option:
//   DECODE_STAGE_HAZARD_EN - when defined, a load-use interlock inserts one
//                            bubble and counts it in bubble_cnt. When
//                            undefined, the hazard is tied to 0 and
//                            bubble_cnt stays 0.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   input handshake for instr and in_pc
//   instr, in_pc          instruction word and its address
//   flush                 discards the held entry and blocks the incoming one
//   out_valid / out_ready output handshake for the registered decode
//   op                    ALU op (AND 0000, OR 0001, ADD 0010, SUB 0110,
//                         NOR 1100, SLT 0111, undefined 1111)
//   ssel                  operand-B select (00 imm, 10 rs2)
//   imm                   sign-extended 16-bit immediate
//   rs1_id, rs2_id        source register IDs (0 when unused)
//   rdst_id               destination register ID (0 when unused)
//   jump_type             000 none, 001 beq, 010 j/jal, 011 jr, 100 bne
//   jump_addr             {zeros, instr[25:0]} for j/jal, else 0
//   we_dmem, we_regfile   store enable, register write enable
//   is_load               held instruction is a load
//   out_pc                PC of the held instruction
//   illegal               held instruction could not be decoded
//   bubble_cnt            number of load-use bubbles inserted (wraps)
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] instr,
  input  logic [DWIDTH-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        op,
  output logic [1:0]        ssel,
  output logic [DWIDTH-1:0] imm,
  output logic [4:0]        rs1_id,
  output logic [4:0]        rs2_id,
  output logic [4:0]        rdst_id,
  output logic [2:0]        jump_type,
  output logic [DWIDTH-1:0] jump_addr,
  output logic              we_dmem,
  output logic              we_regfile,
  output logic              is_load,
  output logic [DWIDTH-1:0] out_pc,
  output logic              illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Primary opcodes
  localparam logic [5:0] OpcRtype = 6'b000000;
  localparam logic [5:0] OpcJ     = 6'b000010;
  localparam logic [5:0] OpcJal   = 6'b000011;
  localparam logic [5:0] OpcBeq   = 6'b000100;
  localparam logic [5:0] OpcBne   = 6'b000101;
  localparam logic [5:0] OpcAddi  = 6'b001000;
  localparam logic [5:0] OpcSlti  = 6'b001010;
  localparam logic [5:0] OpcLw    = 6'b100011;
  localparam logic [5:0] OpcSw    = 6'b101011;

  // R-type function codes
  localparam logic [5:0] FnJr  = 6'b001000;
  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnNor = 6'b100111;
  localparam logic [5:0] FnSlt = 6'b101010;

  // ALU operations
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluNor = 4'b1100;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluBad = 4'b1111;

  localparam logic [1:0] SselImm = 2'b00;
  localparam logic [1:0] SselRs2 = 2'b10;

  localparam logic [2:0] JtNone = 3'b000;
  localparam logic [2:0] JtBeq  = 3'b001;
  localparam logic [2:0] JtJmp  = 3'b010;
  localparam logic [2:0] JtJr   = 3'b011;
  localparam logic [2:0] JtBne  = 3'b100;

  localparam logic [4:0] RegRa = 5'd31;

  typedef struct packed {
    logic [3:0]        op;
    logic [1:0]        ssel;
    logic [DWIDTH-1:0] imm;
    logic [4:0]        rs1_id;
    logic [4:0]        rs2_id;
    logic [4:0]        rdst_id;
    logic [2:0]        jump_type;
    logic [DWIDTH-1:0] jump_addr;
    logic              we_dmem;
    logic              we_regfile;
    logic              is_load;
    logic              illegal;
    logic [DWIDTH-1:0] pc;
  } dec_t;

  // Instruction fields
  logic [5:0]        opcode;
  logic [4:0]        f_rs;
  logic [4:0]        f_rt;
  logic [4:0]        f_rd;
  logic [5:0]        funct;
  logic [DWIDTH-1:0] imm_sext;
  logic [DWIDTH-1:0] jaddr;

  assign opcode   = instr[31:26];
  assign f_rs     = instr[25:21];
  assign f_rt     = instr[20:16];
  assign f_rd     = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = {{(DWIDTH-16){instr[15]}}, instr[15:0]};
  assign jaddr    = {{(DWIDTH-26){1'b0}}, instr[25:0]};

  // R-type ALU function lookup
  logic       r_alu;
  logic [3:0] r_op;

  always_comb begin
    r_alu = 1'b1;
    r_op  = AluAdd;
    case (funct)
      FnAdd:   r_op = AluAdd;
      FnSub:   r_op = AluSub;
      FnAnd:   r_op = AluAnd;
      FnOr:    r_op = AluOr;
      FnNor:   r_op = AluNor;
      FnSlt:   r_op = AluSlt;
      default: r_alu = 1'b0;
    endcase
  end

  // Combinational decode of the incoming instruction
  dec_t dec;

  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    case (opcode)
      OpcRtype: begin
        if (r_alu) begin
          dec.op         = r_op;
          dec.ssel       = SselRs2;
          dec.rs1_id     = f_rs;
          dec.rs2_id     = f_rt;
          dec.rdst_id    = f_rd;
          dec.we_regfile = 1'b1;
        end else if (funct == FnJr) begin
          dec.rs1_id    = f_rs;
          dec.jump_type = JtJr;
        end else begin
          dec.op      = AluBad;
          dec.illegal = 1'b1;
        end
      end
      OpcAddi, OpcSlti, OpcLw: begin
        dec.op         = (opcode == OpcSlti) ? AluSlt : AluAdd;
        dec.ssel       = SselImm;
        dec.imm        = imm_sext;
        dec.rs1_id     = f_rs;
        dec.rdst_id    = f_rt;
        dec.we_regfile = 1'b1;
        dec.is_load    = (opcode == OpcLw);
      end
      OpcSw: begin
        dec.op      = AluAdd;
        dec.ssel    = SselImm;
        dec.imm     = imm_sext;
        dec.rs1_id  = f_rs;
        dec.rs2_id  = f_rt;
        dec.we_dmem = 1'b1;
      end
      OpcBeq, OpcBne: begin
        // Branch offset is carried in imm for target computation downstream
        dec.op        = AluSub;
        dec.ssel      = SselRs2;
        dec.imm       = imm_sext;
        dec.rs1_id    = f_rs;
        dec.rs2_id    = f_rt;
        dec.jump_type = (opcode == OpcBne) ? JtBne : JtBeq;
      end
      OpcJ: begin
        dec.jump_type = JtJmp;
        dec.jump_addr = jaddr;
      end
      OpcJal: begin
        dec.jump_type  = JtJmp;
        dec.jump_addr  = jaddr;
        dec.rdst_id    = RegRa;
        dec.we_regfile = 1'b1;
      end
      default: begin
        dec.op      = AluBad;
        dec.illegal = 1'b1;
      end
    endcase
  end

  // Output register
  logic out_valid_q;
  logic out_valid_d;
  dec_t held_q;
  logic accept;
  logic hazard;
  logic bubble;

`ifdef DECODE_STAGE_HAZARD_EN
  // Unused source fields decode to 0 and a zero destination is excluded,
  // so comparing the decoded IDs directly only matches real dependencies.
  assign hazard = out_valid_q && held_q.is_load && (held_q.rdst_id != 5'd0) && in_valid &&
                  ((dec.rs1_id == held_q.rdst_id) || (dec.rs2_id == held_q.rdst_id));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  // A bubble is only a cycle where the load actually leaves with the consumer stalled
  assign bubble   = hazard && out_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      held_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      if (accept) begin
        held_q <= dec;
      end
    end
  end

`ifdef DECODE_STAGE_HAZARD_EN
  logic [CNT_W-1:0] bubble_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
    end else if (bubble) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_cnt_q;
`else
  logic bubble_unused;
  assign bubble_unused = bubble;
  assign bubble_cnt    = '0;
`endif

  assign out_valid  = out_valid_q;
  assign op         = held_q.op;
  assign ssel       = held_q.ssel;
  assign imm        = held_q.imm;
  assign rs1_id     = held_q.rs1_id;
  assign rs2_id     = held_q.rs2_id;
  assign rdst_id    = held_q.rdst_id;
  assign jump_type  = held_q.jump_type;
  assign jump_addr  = held_q.jump_addr;
  assign we_dmem    = held_q.we_dmem;
  assign we_regfile = held_q.we_regfile;
  assign is_load    = held_q.is_load;
  assign out_pc     = held_q.pc;
  assign illegal    = held_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Scoreboard bench for decode_stage. The stimulus side pushes the
// hand-computed decode of every instruction it expects to be delivered; a
// separate monitor pops and compares on each output transfer. Directed
// checks cover reset, stalls, flush, the load-use bubble and counter wrap
// (CNT_W is set to 2 so the wrap is reachable).
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 2;

`ifdef DECODE_STAGE_HAZARD_EN
  localparam bit Hz = 1'b1;
`else
  localparam bit Hz = 1'b0;
`endif

  typedef logic [123:0] vec_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] instr;
  logic [DW-1:0] in_pc;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    op;
  logic [1:0]    ssel;
  logic [DW-1:0] imm;
  logic [4:0]    rs1_id;
  logic [4:0]    rs2_id;
  logic [4:0]    rdst_id;
  logic [2:0]    jump_type;
  logic [DW-1:0] jump_addr;
  logic          we_dmem;
  logic          we_regfile;
  logic          is_load;
  logic [DW-1:0] out_pc;
  logic          illegal;
  logic [CW-1:0] bubble_cnt;

  decode_stage #(
    .DWIDTH(DW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op        (op),
    .ssel      (ssel),
    .imm       (imm),
    .rs1_id    (rs1_id),
    .rs2_id    (rs2_id),
    .rdst_id   (rdst_id),
    .jump_type (jump_type),
    .jump_addr (jump_addr),
    .we_dmem   (we_dmem),
    .we_regfile(we_regfile),
    .is_load   (is_load),
    .out_pc    (out_pc),
    .illegal   (illegal),
    .bubble_cnt(bubble_cnt)
  );

  vec_t act;
  assign act = {op, ssel, imm, rs1_id, rs2_id, rdst_id, jump_type, jump_addr,
                we_dmem, we_regfile, is_load, illegal, out_pc};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass;
  int   n_total;
  vec_t q[$];

  task automatic check(input string name, input vec_t got, input vec_t want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  function automatic vec_t mk(input logic [3:0] e_op, input logic [1:0] e_ssel,
                              input logic [31:0] e_imm, input logic [4:0] e_rs1,
                              input logic [4:0] e_rs2, input logic [4:0] e_rd,
                              input logic [2:0] e_jt, input logic [31:0] e_ja,
                              input logic e_wd, input logic e_wr, input logic e_ld,
                              input logic e_ill, input logic [31:0] e_pc);
    return {e_op, e_ssel, e_imm, e_rs1, e_rs2, e_rd, e_jt, e_ja, e_wd, e_wr, e_ld, e_ill, e_pc};
  endfunction

  // Monitor: every output transfer must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_output", act, '0);
      end else begin
        check("scoreboard", act, q.pop_front());
      end
    end
  end

  // Present an instruction until accepted; optionally expect it downstream
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input vec_t e,
                      input bit push);
    int n;
    instr    = ins;
    in_pc    = pc;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    else if (push) q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Instruction encodings
  localparam logic [31:0] IAddi = 32'h2128FFFC;  // addi $8,$9,-4
  localparam logic [31:0] IAdd  = 32'h010B5020;  // add  $10,$8,$11
  localparam logic [31:0] ISub  = 32'h00221822;  // sub  $3,$1,$2
  localparam logic [31:0] IAnd  = 32'h00A62024;  // and  $4,$5,$6
  localparam logic [31:0] IOr   = 32'h00A63825;  // or   $7,$5,$6
  localparam logic [31:0] INor  = 32'h00A64827;  // nor  $9,$5,$6
  localparam logic [31:0] ISlt  = 32'h0064102A;  // slt  $2,$3,$4
  localparam logic [31:0] IJr   = 32'h03E00008;  // jr   $31
  localparam logic [31:0] ISlti = 32'h28C50064;  // slti $5,$6,100
  localparam logic [31:0] ISw   = 32'hAFA80004;  // sw   $8,4($29)
  localparam logic [31:0] IBeq  = 32'h1022FFFF;  // beq  $1,$2,-1
  localparam logic [31:0] IBne  = 32'h14220002;  // bne  $1,$2,2
  localparam logic [31:0] IJ    = 32'h08100000;  // j    0x0100000
  localparam logic [31:0] IJal  = 32'h0C000010;  // jal  0x10
  localparam logic [31:0] ILw   = 32'h8D280000;  // lw   $8,0($9)
  localparam logic [31:0] IAdd1 = 32'h216A0001;  // addi $10,$11,1
  localparam logic [31:0] IBad  = 32'hFC000000;  // opcode 111111
  localparam logic [31:0] IBadR = 32'h00000001;  // R-type funct 000001

  function automatic vec_t e_add(input logic [31:0] pc);
    return mk(4'b0010, 2'b10, 32'h0, 5'd8, 5'd11, 5'd10, 3'b000, 32'h0, 0, 1, 0, 0, pc);
  endfunction

  function automatic vec_t e_lw(input logic [31:0] pc);
    return mk(4'b0010, 2'b00, 32'h0, 5'd9, 5'd0, 5'd8, 3'b000, 32'h0, 0, 1, 1, 0, pc);
  endfunction

  int exp_bub;

  initial begin
    vec_t e;
    n_pass    = 0;
    n_total   = 0;
    exp_bub   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    instr     = '0;
    in_pc     = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    #3;
    check("reset_outputs", act, '0);
    check("reset_out_valid", out_valid, 0);
    check("reset_bubble_cnt", bubble_cnt, 0);
    #4;
    rst = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 1);

    // addi with one-cycle latency
    send(IAddi, 32'h100, mk(4'b0010, 2'b00, 32'hFFFFFFFC, 5'd9, 5'd0, 5'd8, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h100), 1);
    check("addi_latency_valid", out_valid, 1);

    // Decode table sweep
    send(IAdd,  32'h104, e_add(32'h104), 1);
    send(ISub,  32'h108, mk(4'b0110, 2'b10, 32'h0, 5'd1, 5'd2, 5'd3, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h108), 1);
    send(IAnd,  32'h10C, mk(4'b0000, 2'b10, 32'h0, 5'd5, 5'd6, 5'd4, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h10C), 1);
    send(IOr,   32'h110, mk(4'b0001, 2'b10, 32'h0, 5'd5, 5'd6, 5'd7, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h110), 1);
    send(INor,  32'h114, mk(4'b1100, 2'b10, 32'h0, 5'd5, 5'd6, 5'd9, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h114), 1);
    send(ISlt,  32'h118, mk(4'b0111, 2'b10, 32'h0, 5'd3, 5'd4, 5'd2, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h118), 1);
    send(IJr,   32'h11C, mk(4'b0000, 2'b00, 32'h0, 5'd31, 5'd0, 5'd0, 3'b011, 32'h0,
                            0, 0, 0, 0, 32'h11C), 1);
    send(ISlti, 32'h120, mk(4'b0111, 2'b00, 32'd100, 5'd6, 5'd0, 5'd5, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h120), 1);
    send(ISw,   32'h124, mk(4'b0010, 2'b00, 32'd4, 5'd29, 5'd8, 5'd0, 3'b000, 32'h0,
                            1, 0, 0, 0, 32'h124), 1);
    send(IBeq,  32'h128, mk(4'b0110, 2'b10, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd0, 3'b001, 32'h0,
                            0, 0, 0, 0, 32'h128), 1);
    send(IJ,    32'h12C, mk(4'b0000, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0, 3'b010, 32'h00100000,
                            0, 0, 0, 0, 32'h12C), 1);
    send(IBadR, 32'h130, mk(4'b1111, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0,
                            0, 0, 0, 1, 32'h130), 1);
    idle(2);

    // Load-use: lw $8 then add using $8
    send(ILw, 32'h200, e_lw(32'h200), 1);
    instr    = IAdd;
    in_pc    = 32'h204;
    in_valid = 1'b1;
    @(negedge clk);
`ifdef DECODE_STAGE_HAZARD_EN
    check("hz_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    exp_bub = 1;
    check("hz_bubble_valid", out_valid, 0);
    check("hz_bubble_cnt", bubble_cnt, vec_t'(exp_bub));
    @(negedge clk);
    check("hz_in_ready_after", in_ready, 1);
`else
    check("nohz_in_ready", in_ready, 1);
`endif
    q.push_back(e_add(32'h204));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("add_after_lw_valid", out_valid, 1);
    idle(2);

    // Load-use through rs2 (sw rt = $8)
    send(ILw, 32'h210, e_lw(32'h210), 1);
    send(ISw, 32'h214, mk(4'b0010, 2'b00, 32'd4, 5'd29, 5'd8, 5'd0, 3'b000, 32'h0,
                          1, 0, 0, 0, 32'h214), 1);
    if (Hz) exp_bub = 2;
    check("rs2_bubble_cnt", bubble_cnt, vec_t'(exp_bub));

    // Independent consumer: no bubble
    send(ILw, 32'h220, e_lw(32'h220), 1);
    send(IAdd1, 32'h224, mk(4'b0010, 2'b00, 32'd1, 5'd11, 5'd0, 5'd10, 3'b000, 32'h0,
                            0, 1, 0, 0, 32'h224), 1);
    check("nodep_bubble_cnt", bubble_cnt, vec_t'(exp_bub));

    // Two more dependent pairs: counter reaches all-ones then wraps
    for (int k = 0; k < 2; k++) begin
      send(ILw, 32'h230 + 8 * k, e_lw(32'h230 + 8 * k), 1);
      send(IAdd, 32'h234 + 8 * k, e_add(32'h234 + 8 * k), 1);
      if (Hz) exp_bub = (exp_bub + 1) % 4;
      check("wrap_bubble_cnt", bubble_cnt, vec_t'(exp_bub));
    end
    idle(2);

    // Held bne under backpressure
    out_ready = 1'b0;
    e = mk(4'b0110, 2'b10, 32'd2, 5'd1, 5'd2, 5'd0, 3'b100, 32'h0, 0, 0, 0, 0, 32'h300);
    send(IBne, 32'h300, e, 1);
    instr    = IAddi;
    in_pc    = 32'h304;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", act, e);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_jump_type", jump_type, 3'b100);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Flush with held jal and a competing input
    out_ready = 1'b0;
    e = mk(4'b0000, 2'b00, 32'h0, 5'd0, 5'd0, 5'd31, 3'b010, 32'h10, 0, 1, 0, 0, 32'h400);
    send(IJal, 32'h400, e, 0);
    @(negedge clk);
    check("jal_held", act, e);
    flush    = 1'b1;
    instr    = IAddi;
    in_pc    = 32'h404;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    out_ready = 1'b1;
    idle(3);
    check("flush_stays_empty", out_valid, 0);

    // Illegal opcode held under stall, then asynchronous reset
    out_ready = 1'b0;
    e = mk(4'b1111, 2'b00, 32'h0, 5'd0, 5'd0, 5'd0, 3'b000, 32'h0, 0, 0, 0, 1, 32'h500);
    send(IBad, 32'h500, e, 0);
    @(negedge clk);
    check("illegal_held", act, e);
    check("illegal_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outputs", act, '0);
    check("async_rst_valid", out_valid, 0);
    check("async_rst_bubble_cnt", bubble_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    // Nothing replayed: only this new instruction may appear
    send(IAdd, 32'h600, e_add(32'h600), 1);
    idle(3);

    check("queue_drained", vec_t'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, instruction/PC/immediate width.
REQ-002 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 SHALL use one clock and an asynchronous active-high reset; ports as below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  instr/in_pc valid.
REQ-007 in_ready  out  1  stage accepts input this cycle.
REQ-008 instr  in  DWIDTH  MIPS instruction.
REQ-009 in_pc  in  DWIDTH  instruction address.
REQ-010 flush  in  1  discard held and incoming instruction.
REQ-011 out_valid  out  1  registered decode valid.
REQ-012 out_ready  in  1  downstream accepts output.
REQ-013 op  out  4  ALU op: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111, undefined 1111.
REQ-014 ssel  out  2  operand-B select: 00 imm, 10 rs2.
REQ-015 imm  out  DWIDTH  extended immediate.
REQ-016 rs1_id, rs2_id, rdst_id  out  5 each  register IDs; unused fields 0.
REQ-017 jump_type  out  3  000 none, 001 beq, 010 j/jal, 011 jr, 100 bne.
REQ-018 jump_addr  out  DWIDTH  {zeros, instr[25:0]} for j/jal, else 0.
REQ-019 we_dmem, we_regfile, is_load  out  1 each  store, reg write, load.
REQ-020 out_pc  out  DWIDTH  PC of held instruction.
REQ-021 illegal  out  1  held instruction undecodable.
REQ-022 bubble_cnt  out  CNT_W  count of inserted load-use bubbles.

Function
REQ-023 Decode: R-type (op 000000) funct add/sub/and/or/nor/slt, rd dest, ssel 10, we_regfile 1; jr (001000) jump_type 011, we_regfile 0.
REQ-024 addi/slti/lw: rt dest, imm sign-extended, ssel 00, we_regfile 1; op ADD/SLT/ADD; lw sets is_load.
REQ-025 sw: rs2_id=rt, rdst_id 0, op ADD, we_dmem 1; beq/bne (000100/000101): op SUB, ssel 10, jump_type 001/100.
REQ-026 j (000010): jump_type 010, no write; jal (000011): jump_type 010, rdst_id 31, we_regfile 1.
REQ-027 Any other opcode/funct: all fields 0, op 1111, illegal 1; still passed downstream as a valid entry.
REQ-028 Single-entry output register; latency 1 cycle from acceptance to out_valid.
REQ-029 Accept when in_valid && in_ready; in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-030 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-031 flush: next edge out_valid=0; input presented that cycle not accepted; flush dominates all else.
REQ-032 Hazard: out_valid && is_load && rdst_id!=0 && in_valid && incoming rs1_id or used rs2_id equals held rdst_id.
REQ-033 On hazard with out_ready: held entry leaves, out_valid=0 next cycle (bubble), bubble_cnt+1, instruction accepted next cycle.
REQ-034 bubble_cnt SHALL wrap from all-ones to 0; increments only on an actual bubble.

Reset
REQ-035 rst SHALL asynchronously clear out_valid, all decode outputs, out_pc, illegal, and bubble_cnt to 0; in_ready 1 after release.
REQ-036 rst mid-transfer SHALL drop held instruction; none replayed.

Configuration
REQ-037 Macro DECODE_STAGE_HAZARD_EN defined: REQ-032..034 interlock active.
REQ-038 Undefined: hazard tied 0, bubble_cnt constant 0, no bubbles inserted.

Verification
REQ-039 addi $t0,$t1,-4 (0x2128FFFC) -> next cycle out_valid=1, op 0010, rs1 9, rdst 8, imm 0xFFFFFFFC, ssel 00, we_regfile 1.
REQ-040 lw $8,0($9) then add $10,$8,$11, out_ready=1 -> one bubble cycle, bubble_cnt=1, add appears 2 cycles after lw.
REQ-041 out_ready=0 for 3 cycles with held bne -> outputs stable, in_ready=0, jump_type 100 throughout.
REQ-042 flush asserted with held jal and in_valid=1 -> next cycle out_valid=0; incoming instruction not accepted.
REQ-043 opcode 111111 -> illegal=1, op 1111, we_regfile 0, we_dmem 0; rst asserted mid-stall -> all outputs 0 immediately.
